reset_sequencer: RTL

Parametrised reset conditioner for the board-level designs (7-segment display and later projects). Takes the asynchronous active-low board reset and a raw, bouncy pushbutton reset. Produces CHANNELS active-high synchronous resets with asynchronous assertion, synchronous deassertion, a guaranteed minimum hold time and staggered release. A ready flag tells downstream logic when every channel is out of reset.

---
 rtl/reset_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Reset conditioner. Combines the asynchronous active-low board
//             reset with a debounced pushbutton reset and drives CHANNELS
//             active-high resets. Assertion is asynchronous and deassertion is
//             synchronous. The channels are held for a minimum time and are
//             then released one after another, bit 0 first. A ready flag goes
//             high once every channel is out of reset.
//  Options  : RESET_SEQUENCER_COUNT_EN - adds the 8-bit saturating output
//             reset_count, which counts button resets taken in RELEASE or RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 8,
   parameter int CHANNELS        = 3,
   parameter int STAGGER_CYCLES  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_reset,
   output logic [CHANNELS-1:0] rst_out,
   output logic                ready
`ifdef RESET_SEQUENCER_COUNT_EN
   ,
   output logic [7:0]          reset_count
`endif
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int TW = $clog2(STAGGER_CYCLES + 1);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] rst_sync;
   logic [SYNC_STAGES-1:0] btn_sync;
   logic                   rst_ok;
   logic                   btn_s;
   logic [DW-1:0]          deb_cnt;
   logic                   btn_filt;

   state_t                 state, state_nxt;
   logic [HW-1:0]          hold_cnt, hold_nxt;
   logic [TW-1:0]          stag_cnt, stag_nxt;
   logic [CW-1:0]          ch_idx, ch_nxt;
   logic [CHANNELS-1:0]    rst_nxt;
   logic                   ready_nxt;

   assign rst_ok = rst_sync[SYNC_STAGES-1];
   assign btn_s  = btn_sync[SYNC_STAGES-1];

   // Reset release synchroniser: cleared at once by reset, fills with ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // Pushbutton synchroniser.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_sync <= '0;
      end else begin
         btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_reset};
      end
   end

   // Debounce: the filtered level changes after DEBOUNCE_CYCLES disagreeing
   // samples in a row. One agreeing sample restarts the count. The counter
   // stops at DEBOUNCE_CYCLES-1, so it cannot wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_cnt  <= '0;
         btn_filt <= 1'b0;
      end else if (btn_s != btn_filt) begin
         if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            btn_filt <= btn_s;
            deb_cnt  <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_HOLD;
         hold_cnt <= '0;
         stag_cnt <= '0;
         ch_idx   <= '0;
         rst_out  <= '1;
         ready    <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         stag_cnt <= stag_nxt;
         ch_idx   <= ch_nxt;
         rst_out  <= rst_nxt;
         ready    <= ready_nxt;
      end
   end

   // Next state: hold, then staggered release, then run. A filtered button
   // press drops back to HOLD and reasserts every channel at once.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      stag_nxt  = stag_cnt;
      ch_nxt    = ch_idx;
      rst_nxt   = rst_out;
      ready_nxt = ready;
      case (state)
         ST_HOLD: begin
            rst_nxt   = '1;
            ready_nxt = 1'b0;
            if (btn_filt) begin
               hold_nxt = '0;
            end else if (rst_ok) begin
               if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                  // Hold is complete. Channel 0 is released on this edge.
                  hold_nxt   = '0;
                  stag_nxt   = '0;
                  ch_nxt     = CW'(1);
                  rst_nxt[0] = 1'b0;
                  if (CHANNELS == 1) begin
                     state_nxt = ST_RUN;
                     ready_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_RELEASE;
                  end
               end else begin
                  hold_nxt = hold_cnt + HW'(1);
               end
            end
         end
         ST_RELEASE: begin
            if (btn_filt) begin
               state_nxt = ST_HOLD;
               hold_nxt  = '0;
               rst_nxt   = '1;
               ready_nxt = 1'b0;
            end else if (stag_cnt == TW'(STAGGER_CYCLES - 1)) begin
               stag_nxt = '0;
               for (int i = 0; i < CHANNELS; i++) begin
                  if (CW'(i) == ch_idx) begin
                     rst_nxt[i] = 1'b0;
                  end
               end
               if (ch_idx == CW'(CHANNELS - 1)) begin
                  state_nxt = ST_RUN;
                  ready_nxt = 1'b1;
               end else begin
                  ch_nxt = ch_idx + CW'(1);
               end
            end else begin
               stag_nxt = stag_cnt + TW'(1);
            end
         end
         ST_RUN: begin
            rst_nxt   = '0;
            ready_nxt = 1'b1;
            if (btn_filt) begin
               state_nxt = ST_HOLD;
               hold_nxt  = '0;
               rst_nxt   = '1;
               ready_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            rst_nxt   = '1;
            ready_nxt = 1'b0;
         end
      endcase
   end

`ifdef RESET_SEQUENCER_COUNT_EN
   logic press;

   // A press is counted on the edge where the FSM leaves RELEASE or RUN.
   // That edge happens once for each rising edge of btn_filt.
   assign press = btn_filt && ((state == ST_RELEASE) || (state == ST_RUN));

   // Saturating press counter. Only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reset_count <= 8'd0;
      end else if (press && (reset_count != 8'hFF)) begin
         reset_count <= reset_count + 8'd1;
      end
   end
`else
   // No press counter in this build.
`endif

endmodule
`default_nettype wire
